mic_sound_detector: RTL and testbench

//  Receive-side counterpart to the PWM audio output: drives the Nexys A7 PDM microphone (M_CLK/M_LRSEL), samples the
//  1-bit PDM stream, and decimates it with a boxcar window into a per-window amplitude. It also reports sustained loud

---
 rtl/mic_sound_detector.sv | 191 +++++++++++++++++++
 tb/tb_mic_sound_detector.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mic_sound_detector.sv
// PDM microphone front end: drives M_CLK, decimates M_DATA over boxcar windows and flags sustained loud sound.
// Optional peak-hold of the window amplitude is built when the MIC_PEAK_EN macro is defined.
module mic_sound_detector #(
  parameter int WIN_LOG2  = 8,
  parameter int THRESHOLD = 40,
  parameter int HOLD_WIN  = 16
) (
  input  logic                pulse_5MHz,
  input  logic                reset,
  input  logic                enable,
  input  logic                M_DATA,
  output logic                M_CLK,
  output logic                M_LRSEL,
  output logic [WIN_LOG2-1:0] amplitude,
  output logic                sample_valid,
  output logic                sound_detected,
  output logic [WIN_LOG2-1:0] peak_amp
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    DETECTED = 2'd2
  } state_t;

  localparam logic [WIN_LOG2:0]   HALF    = {1'b0, 1'b1, {(WIN_LOG2-1){1'b0}}};
  localparam logic [WIN_LOG2-1:0] AMP_MAX = {WIN_LOG2{1'b1}};
  localparam logic [WIN_LOG2:0]   THR     = (WIN_LOG2+1)'(THRESHOLD);
  localparam logic [7:0]          HOLD    = 8'(HOLD_WIN);

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  mclk_r;
  logic [WIN_LOG2-1:0]   cnt_r;
  logic [WIN_LOG2:0]     ones_r;
  logic [7:0]            loud_r;
  logic [WIN_LOG2-1:0]   amp_r;
  logic                  sv_r;
  logic                  det_r;

  logic                  active_s;
  logic                  sample_s;
  logic                  win_end_s;
  logic [WIN_LOG2:0]     total_s;
  logic [WIN_LOG2:0]     diff_s;
  logic [WIN_LOG2-1:0]   amp_s;
  logic                  loud_s;
  logic [7:0]            loud_nxt_s;
  logic                  hit_s;

  // Window arithmetic: ones total including the current sample, distance from half-scale, loud-run update.
  always_comb begin
    active_s   = 1'b0;
    sample_s   = 1'b0;
    win_end_s  = 1'b0;
    total_s    = {(WIN_LOG2+1){1'b0}};
    diff_s     = {(WIN_LOG2+1){1'b0}};
    amp_s      = {WIN_LOG2{1'b0}};
    loud_s     = 1'b0;
    loud_nxt_s = loud_r;
    hit_s      = 1'b0;

    active_s  = enable && (state_r != IDLE);
    sample_s  = active_s && mclk_r;
    win_end_s = sample_s && (cnt_r == AMP_MAX);
    total_s   = ones_r + {{WIN_LOG2{1'b0}}, M_DATA};
    if (total_s >= HALF) begin
      diff_s = total_s - HALF;
    end else begin
      diff_s = HALF - total_s;
    end
    if (diff_s > {1'b0, AMP_MAX}) begin
      amp_s = AMP_MAX;
    end else begin
      amp_s = diff_s[WIN_LOG2-1:0];
    end
    loud_s = ({1'b0, amp_s} >= THR);
    if (win_end_s) begin
      if (!loud_s) begin
        loud_nxt_s = 8'd0;
      end else if (loud_r >= HOLD) begin
        loud_nxt_s = HOLD;
      end else begin
        loud_nxt_s = loud_r + 8'd1;
      end
    end else begin
      loud_nxt_s = loud_r;
    end
    hit_s = win_end_s && (state_r == ARMED) && loud_s && (loud_nxt_s == HOLD);
  end

  // Next-state logic; dropping enable always returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable) begin
          state_nxt_s = ARMED;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      ARMED: begin
        if (!enable) begin
          state_nxt_s = IDLE;
        end else if (hit_s) begin
          state_nxt_s = DETECTED;
        end else begin
          state_nxt_s = ARMED;
        end
      end
      DETECTED: begin
        if (!enable) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DETECTED;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge pulse_5MHz) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Mic clock, sample/ones counters, amplitude and detection flag; a partial window is dropped when idle.
  always_ff @(posedge pulse_5MHz) begin
    if (reset) begin
      mclk_r <= 1'b0;
      cnt_r  <= {WIN_LOG2{1'b0}};
      ones_r <= {(WIN_LOG2+1){1'b0}};
      loud_r <= 8'd0;
      amp_r  <= {WIN_LOG2{1'b0}};
      sv_r   <= 1'b0;
      det_r  <= 1'b0;
    end else if (!active_s) begin
      mclk_r <= 1'b0;
      cnt_r  <= {WIN_LOG2{1'b0}};
      ones_r <= {(WIN_LOG2+1){1'b0}};
      loud_r <= 8'd0;
      sv_r   <= 1'b0;
      det_r  <= 1'b0;
    end else begin
      mclk_r <= ~mclk_r;
      sv_r   <= win_end_s;
      loud_r <= loud_nxt_s;
      if (sample_s) begin
        cnt_r  <= cnt_r + {{(WIN_LOG2-1){1'b0}}, 1'b1};
        ones_r <= win_end_s ? {(WIN_LOG2+1){1'b0}} : total_s;
      end
      if (win_end_s) begin
        amp_r <= amp_s;
      end
      if (hit_s) begin
        det_r <= 1'b1;
      end
    end
  end

`ifdef MIC_PEAK_EN
  logic [WIN_LOG2-1:0] peak_r;

  // Peak-hold of window amplitude, restarted each time listening begins.
  always_ff @(posedge pulse_5MHz) begin
    if (reset) begin
      peak_r <= {WIN_LOG2{1'b0}};
    end else if ((state_r == IDLE) && enable) begin
      peak_r <= {WIN_LOG2{1'b0}};
    end else if (win_end_s && (amp_s > peak_r)) begin
      peak_r <= amp_s;
    end
  end

  assign peak_amp = peak_r;
`else
  assign peak_amp = {WIN_LOG2{1'b0}};
`endif

  assign M_CLK          = mclk_r;
  assign M_LRSEL        = 1'b0;
  assign amplitude      = amp_r;
  assign sample_valid   = sv_r;
  assign sound_detected = det_r;

endmodule

// File: tb/tb_mic_sound_detector.sv
// Self-checking bench for mic_sound_detector (WIN_LOG2=4, THRESHOLD=6, HOLD_WIN=3) against a window-level model.
module tb_mic_sound_detector;

  localparam int W   = 4;
  localparam int NS  = 16;
  localparam int THR = 6;
  localparam int HLD = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         m_data;
  logic         m_clk;
  logic         m_lrsel;
  logic [W-1:0] amplitude;
  logic         sample_valid;
  logic         sound_detected;
  logic [W-1:0] peak_amp;

  int n_checks = 0;
  int n_fail   = 0;

  int m_amp  = 0;
  int m_peak = 0;
  int m_loud = 0;
  int m_det  = 0;

  mic_sound_detector #(.WIN_LOG2(W), .THRESHOLD(THR), .HOLD_WIN(HLD)) dut (
    .pulse_5MHz     (clk),
    .reset          (reset),
    .enable         (enable),
    .M_DATA         (m_data),
    .M_CLK          (m_clk),
    .M_LRSEL        (m_lrsel),
    .amplitude      (amplitude),
    .sample_valid   (sample_valid),
    .sound_detected (sound_detected),
    .peak_amp       (peak_amp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_peak();
`ifdef MIC_PEAK_EN
    return m_peak;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_mclk"}, m_clk, 0);
    check({tag, "_sv"}, sample_valid, 0);
    check({tag, "_det"}, sound_detected, 0);
    check({tag, "_amp"}, amplitude, m_amp);
    check({tag, "_peak"}, peak_amp, exp_peak());
  endtask

  task automatic start_listen();
    enable = 1'b1;
    tick();
    m_loud = 0;
    m_det  = 0;
    m_peak = 0;
    check_idle_outputs("arm");
  endtask

  task automatic stop_listen();
    enable = 1'b0;
    tick();
    m_loud = 0;
    m_det  = 0;
    check_idle_outputs("stop");
  endtask

  // Runs n clock edges of a window whose samples come from bits; M_CLK must be high on odd edges.
  task automatic run_edges(input logic [NS-1:0] bits, input int n);
    for (int e = 1; e <= n; e++) begin
      m_data = bits[(e-1)/2];
      tick();
      check("mclk", m_clk, e % 2);
      check("lrsel", m_lrsel, 0);
      if (e < 2*NS) begin
        check("sv_quiet", sample_valid, 0);
        check("det_hold", sound_detected, m_det);
      end
    end
  endtask

  task automatic run_window(input logic [NS-1:0] bits);
    int ones;
    ones = $countones(bits);
    run_edges(bits, 2*NS);
    m_amp = (ones >= NS/2) ? ones - NS/2 : NS/2 - ones;
    if (m_amp > m_peak) m_peak = m_amp;
    if (m_det == 0) begin
      if (m_amp >= THR) m_loud = (m_loud + 1 > HLD) ? HLD : m_loud + 1;
      else m_loud = 0;
      if (m_loud == HLD) m_det = 1;
    end
    check("sv_end", sample_valid, 1);
    check("amp", amplitude, m_amp);
    check("det", sound_detected, m_det);
    check("peak", peak_amp, exp_peak());
  endtask

  function automatic logic [NS-1:0] rand_bits();
    logic [NS-1:0] b;
    int level;
    level = $urandom_range(0, NS);
    for (int k = 0; k < NS; k++) b[k] = ($urandom_range(0, NS-1) < level);
    return b;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    m_data = 1'b0;
    repeat (3) tick();
    check("rst_mclk", m_clk, 0);
    check("rst_amp", amplitude, 0);
    check("rst_sv", sample_valid, 0);
    check("rst_det", sound_detected, 0);
    check("rst_peak", peak_amp, 0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_mclk", m_clk, 0);
      check("idle_sv", sample_valid, 0);
    end

    // Constant ones: amplitude 8 every window, detection on the third.
    m_data = 1'b1;
    start_listen();
    for (int i = 0; i < 3; i++) run_window(16'hFFFF);
    stop_listen();

    // Alternating samples: amplitude 0 for ten windows.
    start_listen();
    for (int i = 0; i < 10; i++) run_window(16'h5555);
    stop_listen();

    // A quiet window restarts the loud run; detection on the sixth.
    start_listen();
    run_window(16'hFFFF);
    run_window(16'h0000);
    run_window(16'h00FF);
    run_window(16'hFFFF);
    run_window(16'hFFFF);
    check("pre_det", sound_detected, 0);
    run_window(16'h0000);

    // One-clock drop of enable, then a fresh window.
    stop_listen();
    start_listen();
    run_window(16'h0000);
    stop_listen();

    // Peak hold over amplitudes 3, 8, 5.
    start_listen();
    run_window(16'h07FF);
    run_window(16'hFFFF);
    run_window(16'h0007);
    stop_listen();

    // Randomised sessions, some aborted mid-window.
    for (int s = 0; s < 30; s++) begin
      int nw;
      start_listen();
      nw = $urandom_range(1, 7);
      for (int i = 0; i < nw; i++) run_window(rand_bits());
      if ($urandom_range(0, 1) == 1) run_edges(rand_bits(), $urandom_range(1, 2*NS-1));
      stop_listen();
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        tick();
        check("gap_mclk", m_clk, 0);
        check("gap_sv", sample_valid, 0);
      end
    end

    // Reset wins over enable while listening.
    start_listen();
    run_window(16'hFFFF);
    run_edges(16'hFFFF, 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    m_amp  = 0;
    m_peak = 0;
    m_loud = 0;
    m_det  = 0;
    check("rstov_mclk", m_clk, 0);
    check("rstov_amp", amplitude, 0);
    check("rstov_sv", sample_valid, 0);
    check("rstov_det", sound_detected, 0);
    check("rstov_peak", peak_amp, 0);
    start_listen();
    for (int i = 0; i < 3; i++) run_window(16'hFFFF);
    stop_listen();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
